decimal_entry: RTL and testbench

- Sequential decimal-to-binary operand entry block. It is the inverse of the team's binary-to-decimal seven-segment digit driver.
- Accepts BCD digits one at a time, most significant first, and accumulates value = value*10 + digit.
- On enter, presents the binary result to the 8-bit adder datapath through a valid/ready handshake.
- Default width of 9 bits matches the {carry,sum} display word.

---
 rtl/decimal_entry_if.sv | 30 +++
 rtl/decimal_entry.sv | 118 +++++++++++
 tb/tb_decimal_entry.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/decimal_entry_if.sv
// Handshake bundle for the decimal operand entry block: digit input side,
// control pulses, and the committed-value valid/ready output side.
interface decimal_entry_if #(
    parameter int WIDTH = 9,
    parameter int CNT_W = 2
);
    logic             digit_valid;
    logic [3:0]       digit;
    logic             digit_ready;
    logic             enter;
    logic             clear;
    logic             value_valid;
    logic             value_ready;
    logic [WIDTH-1:0] value;
    logic [CNT_W-1:0] digit_count;
    logic             overflow;
    logic             bad_digit;

    // Producer of digits/controls and consumer of the committed value
    modport master (
        output digit_valid, digit, enter, clear, value_ready,
        input  digit_ready, value_valid, value, digit_count, overflow, bad_digit
    );

    // The entry block itself
    modport slave (
        input  digit_valid, digit, enter, clear, value_ready,
        output digit_ready, value_valid, value, digit_count, overflow, bad_digit
    );
endinterface

// File: rtl/decimal_entry.sv
// Decimal-to-binary operand entry: accumulates BCD digits MSD first as
// acc = acc*10 + digit, then hands the binary result over valid/ready.
// All outputs come straight from flops.
module decimal_entry #(
    parameter int WIDTH      = 9,
    parameter int MAX_DIGITS = 3,
    parameter int CNT_W      = 2
) (
    input logic            clk,
    input logic            rst_n,
    decimal_entry_if.slave bus
);
    typedef enum logic {COLLECT, HOLD} state_t;

    localparam int XW = WIDTH + 4;
    // Largest representable result, zero-extended to the scratch width
    localparam logic [XW-1:0] MAXV = {4'b0, {WIDTH{1'b1}}};

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
    logic             bad;
    logic             rdy;
    logic             vv;
    logic [WIDTH-1:0] val;

    logic [XW-1:0]    acc_x;
    logic [XW-1:0]    sum;
    logic             take;
    logic [WIDTH-1:0] acc_nx;
    logic [CNT_W-1:0] cnt_nx;
    logic             ovf_nx;
    logic             bad_nx;

    // Next accumulator for an offered digit; x10 done as x8 + x2
    always_comb begin
        acc_x  = {4'b0, acc};
        sum    = (acc_x << 3) + (acc_x << 1) + {{WIDTH{1'b0}}, bus.digit};
        take   = bus.digit_valid && rdy;
        acc_nx = acc;
        cnt_nx = cnt;
        ovf_nx = ovf;
        bad_nx = 1'b0;
        if (take) begin
            if (bus.digit > 4'd9) begin
                bad_nx = 1'b1;
            end else if (cnt == CNT_W'(MAX_DIGITS)) begin
                ovf_nx = 1'b1;
            end else if (sum > MAXV) begin
                ovf_nx = 1'b1;
            end else begin
                acc_nx = sum[WIDTH-1:0];
                cnt_nx = cnt + CNT_W'(1);
            end
        end
    end

    // Entry FSM with registered outputs; clear overrides everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= COLLECT;
            acc   <= '0;
            cnt   <= '0;
            ovf   <= 1'b0;
            bad   <= 1'b0;
            rdy   <= 1'b0;
            vv    <= 1'b0;
            val   <= '0;
        end else begin
            bad <= 1'b0;
            if (bus.clear) begin
                state <= COLLECT;
                acc   <= '0;
                cnt   <= '0;
                ovf   <= 1'b0;
                vv    <= 1'b0;
                rdy   <= 1'b1;
            end else begin
                case (state)
                    COLLECT: begin
                        acc <= acc_nx;
                        cnt <= cnt_nx;
                        ovf <= ovf_nx;
                        bad <= bad_nx;
                        if (bus.enter) begin
                            // Same-edge digit is already folded into acc_nx
                            state <= HOLD;
                            val   <= acc_nx;
                            vv    <= 1'b1;
                            rdy   <= 1'b0;
                        end else begin
                            rdy <= 1'b1;
                        end
                    end
                    HOLD: begin
                        if (vv && bus.value_ready) begin
                            state <= COLLECT;
                            acc   <= '0;
                            cnt   <= '0;
                            ovf   <= 1'b0;
                            vv    <= 1'b0;
                            rdy   <= 1'b1;
                        end
                    end
                    default: state <= COLLECT;
                endcase
            end
        end
    end

    assign bus.digit_ready = rdy;
    assign bus.value_valid = vv;
    assign bus.value       = val;
    assign bus.digit_count = cnt;
    assign bus.overflow    = ovf;
    assign bus.bad_digit   = bad;
endmodule

// File: tb/tb_decimal_entry.sv
// Directed bench for decimal_entry: default 9-bit instance plus a 12-bit
// instance for the digit-count limit.
module tb_decimal_entry;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    decimal_entry_if #(.WIDTH(9),  .CNT_W(2)) b1 ();
    decimal_entry_if #(.WIDTH(12), .CNT_W(2)) b2 ();

    decimal_entry #(.WIDTH(9),  .MAX_DIGITS(3), .CNT_W(2)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    decimal_entry #(.WIDTH(12), .MAX_DIGITS(3), .CNT_W(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expectation
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dig(input logic [3:0] d);
        b1.digit_valid = 1'b1;
        b1.digit       = d;
        tick();
        b1.digit_valid = 1'b0;
    endtask

    task automatic dig2(input logic [3:0] d);
        b2.digit_valid = 1'b1;
        b2.digit       = d;
        tick();
        b2.digit_valid = 1'b0;
    endtask

    task automatic ent();
        b1.enter = 1'b1;
        tick();
        b1.enter = 1'b0;
    endtask

    task automatic handshake();
        b1.value_ready = 1'b1;
        tick();
        b1.value_ready = 1'b0;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        b1.digit_valid = 1'b0; b1.digit = '0; b1.enter = 1'b0; b1.clear = 1'b0; b1.value_ready = 1'b0;
        b2.digit_valid = 1'b0; b2.digit = '0; b2.enter = 1'b0; b2.clear = 1'b0; b2.value_ready = 1'b0;
        #1;
        chk("rst_vv",    b1.value_valid, 0);
        chk("rst_value", b1.value,       0);
        chk("rst_cnt",   b1.digit_count, 0);
        chk("rst_ovf",   b1.overflow,    0);
        chk("rst_bad",   b1.bad_digit,   0);
        chk("rst_rdy",   b1.digit_ready, 0);
        #20 rst_n = 1'b1;
        tick();
        chk("rdy_after_rst", b1.digit_ready, 1);

        // 255 with value_ready held high
        b1.value_ready = 1'b1;
        dig(2); chk("t1_cnt1", b1.digit_count, 1);
        dig(5); dig(5);
        ent();
        chk("t1_vv",    b1.value_valid, 1);
        chk("t1_value", b1.value,       255);
        chk("t1_ovf",   b1.overflow,    0);
        chk("t1_cnt",   b1.digit_count, 3);
        chk("t1_rdy",   b1.digit_ready, 0);
        tick();
        chk("t1_vv_done",  b1.value_valid, 0);
        chk("t1_cnt_done", b1.digit_count, 0);
        chk("t1_rdy_done", b1.digit_ready, 1);
        b1.value_ready = 1'b0;

        // 512 does not fit: third digit rejected
        dig(5); dig(1); dig(2);
        chk("t2_ovf_pre", b1.overflow,    1);
        chk("t2_cnt_pre", b1.digit_count, 2);
        ent();
        chk("t2_value", b1.value,       51);
        chk("t2_ovf",   b1.overflow,    1);
        chk("t2_vv",    b1.value_valid, 1);
        handshake();
        chk("t2_vv_done",  b1.value_valid, 0);
        chk("t2_ovf_done", b1.overflow,    0);

        // 12-bit instance: fourth digit rejected by count
        dig2(1); dig2(2); dig2(3); dig2(4);
        b2.enter = 1'b1; tick(); b2.enter = 1'b0;
        chk("t3_value", b2.value,       123);
        chk("t3_ovf",   b2.overflow,    1);
        chk("t3_cnt",   b2.digit_count, 3);
        b2.value_ready = 1'b1; tick(); b2.value_ready = 1'b0;
        chk("t3_vv_done", b2.value_valid, 0);

        // Illegal digit pulses bad_digit for one cycle only
        dig(4'hA);
        chk("t4_bad",     b1.bad_digit,   1);
        chk("t4_bad_cnt", b1.digit_count, 0);
        tick();
        chk("t4_bad_off", b1.bad_digit,   0);
        dig(7);
        ent();
        chk("t4_value", b1.value,    7);
        chk("t4_ovf",   b1.overflow, 0);
        handshake();

        // Digit on the same edge as enter is included
        dig(1); dig(2);
        b1.digit_valid = 1'b1; b1.digit = 4'd4; b1.enter = 1'b1;
        tick();
        b1.digit_valid = 1'b0; b1.enter = 1'b0;
        chk("t4_same_value", b1.value,       124);
        chk("t4_same_cnt",   b1.digit_count, 3);
        handshake();

        // Backpressure: HOLD keeps value and ignores digits
        dig(9);
        ent();
        for (int i = 0; i < 10; i++) begin
            b1.digit_valid = 1'b1; b1.digit = 4'd5;
            tick();
            chk("t5_vv",    b1.value_valid, 1);
            chk("t5_value", b1.value,       9);
            chk("t5_rdy",   b1.digit_ready, 0);
        end
        b1.digit_valid = 1'b0;
        chk("t5_cnt_hold", b1.digit_count, 1);
        handshake();
        chk("t5_vv_done", b1.value_valid, 0);
        dig(3);
        ent();
        chk("t5_fresh", b1.value, 3);
        handshake();

        // Clear discards a same-edge digit and the partial entry
        dig(4); dig(2);
        b1.digit_valid = 1'b1; b1.digit = 4'd3; b1.clear = 1'b1;
        tick();
        b1.digit_valid = 1'b0; b1.clear = 1'b0;
        chk("t6_cnt", b1.digit_count, 0);
        chk("t6_vv",  b1.value_valid, 0);
        dig(6);
        ent();
        chk("t6_value", b1.value, 6);

        // Clear in HOLD drops the pending value without handshake
        b1.clear = 1'b1; tick(); b1.clear = 1'b0;
        chk("t6_clr_hold_vv",  b1.value_valid, 0);
        chk("t6_clr_hold_rdy", b1.digit_ready, 1);
        dig(8);
        ent();
        chk("t6_hold_value", b1.value, 8);

        // Async reset during HOLD, checked before the next edge
        #2 rst_n = 1'b0;
        #1;
        chk("t6_arst_vv",    b1.value_valid, 0);
        chk("t6_arst_value", b1.value,       0);
        chk("t6_arst_cnt",   b1.digit_count, 0);
        #3 rst_n = 1'b1;
        tick();
        chk("t6_arst_rdy", b1.digit_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
